// File: rtl/connect4_pkg.sv
// Board geometry, cell encoding and arbiter state encoding shared by the
// board RAM arbiter and its pixel-to-cell decoder.
package connect4_pkg;

  localparam int NCOLS      = 7;
  localparam int NROWS      = 6;
  localparam int NCELLS     = NCOLS * NROWS;
  localparam int CELL_SHIFT = 6;
  localparam int BOARD_X0   = 96;
  localparam int BOARD_Y0   = 48;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    P1    = 2'd1,
    P2    = 2'd2,
    RSVD  = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    VIDEO  = 2'd0,
    WIN    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/board_ram_arbiter_if.sv
// Game-controller request port and board-RAM port of the arbiter.
// slave = arbiter side, master = game controller plus RAM side.
interface board_ram_arbiter_if #(
  parameter int AW = 6
);
  logic          game_req;
  logic          game_we;
  logic [AW-1:0] game_addr;
  logic [1:0]    game_wdata;
  logic          game_ack;
  logic [1:0]    game_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [1:0]    mem_wdata;
  logic [1:0]    mem_rdata;

  modport slave (
    input  game_req, game_we, game_addr, game_wdata, mem_rdata,
    output game_ack, game_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output game_req, game_we, game_addr, game_wdata, mem_rdata,
    input  game_ack, game_rdata, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/pix_to_cell.sv
// Combinational mapping of a screen pixel to a board cell index and an
// in-board flag; the index is forced to 0 outside the board.
module pix_to_cell
  import connect4_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic [10:0]   x_pixel,
  input  logic [10:0]   y_pixel,
  output logic [AW-1:0] cell_addr,
  output logic          in_board
);

  localparam int CW = 11 - CELL_SHIFT;
  localparam logic [CW-1:0] NCOLS_C = CW'(NCOLS);
  localparam logic [CW-1:0] NROWS_C = CW'(NROWS);

  logic [CW-1:0] col;
  logic [CW-1:0] row;

  // Offsets wrap when left of / above the board, so the >= tests gate them.
  always_comb begin
    col       = CW'((x_pixel - 11'(BOARD_X0)) >> CELL_SHIFT);
    row       = CW'((y_pixel - 11'(BOARD_Y0)) >> CELL_SHIFT);
    in_board  = (x_pixel >= 11'(BOARD_X0)) && (y_pixel >= 11'(BOARD_Y0)) &&
                (col < NCOLS_C) && (row < NROWS_C);
    cell_addr = '0;
    if (in_board) cell_addr = AW'(AW'(row) * AW'(NCOLS) + AW'(col));
  end

endmodule

// File: rtl/board_ram_arbiter.sv
// Shares the single-port board RAM between the scanout renderer and the game
// controller; game accesses run only in a window opened by the vsync fall.
module board_ram_arbiter
  import connect4_pkg::*;
#(
  parameter int WIN_CYCLES = 20000,
  parameter int AW         = 6
) (
  input  logic                      dclk,
  input  logic                      clr,
  input  logic                      vsync,
  input  logic                      vid_enable,
  input  logic [10:0]               x_pixel,
  input  logic [10:0]               y_pixel,
  board_ram_arbiter_if.slave        bus,
  output logic [1:0]                pix_cell,
  output logic                      pix_in_board,
  output logic                      frame_start
);

  localparam int CW = $clog2(WIN_CYCLES + 1);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] win_cnt, win_cnt_nxt;
  logic          vsync_p0;
  logic [AW-1:0] cell_addr;
  logic          in_cell;
  logic [AW-1:0] pix_addr_p1;
  logic          in_p1, vid_p1;
  logic          in_board_p2;
  logic          game_in_range;

  pix_to_cell #(.AW(AW)) u_pix_to_cell (
    .x_pixel   (x_pixel),
    .y_pixel   (y_pixel),
    .cell_addr (cell_addr),
    .in_board  (in_cell)
  );

  assign frame_start   = vsync_p0 & ~vsync;
  assign game_in_range = bus.game_addr < AW'(NCELLS);

  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      state    <= VIDEO;
      win_cnt  <= '0;
      vsync_p0 <= 1'b0;
    end else begin
      state    <= state_nxt;
      win_cnt  <= win_cnt_nxt;
      vsync_p0 <= vsync;
    end
  end

  // The counter<2 guard leaves room for ACCESS+DONE before the window ends.
  always_comb begin
    state_nxt      = state;
    win_cnt_nxt    = win_cnt;
    bus.mem_addr   = pix_addr_p1;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = 2'b00;
    bus.game_ack   = 1'b0;
    bus.game_rdata = 2'b00;
    if (state != VIDEO && win_cnt != '0) win_cnt_nxt = win_cnt - CW'(1);
    case (state)
      VIDEO: begin
        if (frame_start) begin
          state_nxt   = WIN;
          win_cnt_nxt = CW'(WIN_CYCLES);
        end
      end
      WIN: begin
        if (win_cnt < CW'(2) || vid_enable) state_nxt = VIDEO;
        else if (bus.game_req)              state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.mem_addr  = bus.game_addr;
        bus.mem_we    = bus.game_we & game_in_range;
        bus.mem_wdata = bus.game_wdata;
        state_nxt     = DONE;
      end
      DONE: begin
        bus.game_ack   = 1'b1;
        bus.game_rdata = game_in_range ? bus.mem_rdata : 2'b00;
        state_nxt      = WIN;
      end
      default: state_nxt = VIDEO;
    endcase
  end

  // p1: cell address presented to the RAM; p2: RAM data and in-board flag aligned.
  always_ff @(posedge dclk or negedge clr) begin
    if (!clr) begin
      pix_addr_p1 <= '0;
      in_p1       <= 1'b0;
      vid_p1      <= 1'b0;
      in_board_p2 <= 1'b0;
    end else begin
      pix_addr_p1 <= cell_addr;
      in_p1       <= in_cell;
      vid_p1      <= vid_enable;
      in_board_p2 <= in_p1 & vid_p1;
    end
  end

  assign pix_in_board = in_board_p2;
  assign pix_cell     = in_board_p2 ? bus.mem_rdata : 2'b00;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Bench for board_ram_arbiter: directed window/edge scenarios plus randomized
// game accesses and pixel scans checked against an array model of the board.
module tb_board_ram_arbiter;
  import connect4_pkg::*;

  localparam int AW  = 6;
  localparam int WCY = 5;

  logic        dclk = 1'b0;
  logic        clr = 1'b0;
  logic        vsync = 1'b1;
  logic        vid_enable = 1'b0;
  logic [10:0] x_pixel = '0;
  logic [10:0] y_pixel = '0;
  logic [1:0]  pix_cell;
  logic        pix_in_board;
  logic        frame_start;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] ram     [64] = '{default: 2'b00};
  logic [1:0] ref_mem [64] = '{default: 2'b00};

  board_ram_arbiter_if #(.AW(AW)) bus ();

  board_ram_arbiter #(.WIN_CYCLES(WCY), .AW(AW)) dut (
    .dclk         (dclk),
    .clr          (clr),
    .vsync        (vsync),
    .vid_enable   (vid_enable),
    .x_pixel      (x_pixel),
    .y_pixel      (y_pixel),
    .bus          (bus),
    .pix_cell     (pix_cell),
    .pix_in_board (pix_in_board),
    .frame_start  (frame_start)
  );

  always #5 dclk = ~dclk;

  // Board RAM: one-cycle synchronous read, read-before-write.
  always @(posedge dclk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic cyc();
    @(posedge dclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Leaves the caller in the frame_start cycle with inputs not yet settled.
  task automatic start_frame();
    cyc(); vsync = 1'b1;
    cyc(); vsync = 1'b0;
  endtask

  function automatic void ref_pix(input int x, input int y, output bit inb, output int addr);
    int c, r;
    c    = (x - BOARD_X0) / (1 << CELL_SHIFT);
    r    = (y - BOARD_Y0) / (1 << CELL_SHIFT);
    inb  = (x >= BOARD_X0) && (y >= BOARD_Y0) && (c < NCOLS) && (r < NROWS);
    addr = inb ? r * NCOLS + c : 0;
  endfunction

  task automatic test_reset();
    clr = 1'b0;
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 6'd10; bus.game_wdata = 2'd2;
    for (int i = 0; i < 4; i++) begin
      cyc(); vsync = ~vsync; settle();
      n_vec++;
      if ({bus.mem_we, bus.game_ack, bus.game_rdata, bus.mem_addr, bus.mem_wdata,
           pix_cell, pix_in_board, frame_start} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got we=%0d ack=%0d rd=%0d addr=%0d wd=%0d pc=%0d pib=%0d fs=%0d, want all 0",
                 bus.mem_we, bus.game_ack, bus.game_rdata, bus.mem_addr, bus.mem_wdata,
                 pix_cell, pix_in_board, frame_start);
      end
    end
    cyc(); vsync = 1'b1; clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(); settle();
      n_vec++;
      if (bus.mem_we !== 1'b0 || bus.game_ack !== 1'b0) begin
        n_err++;
        $display("FAIL reset_stays_video: got we=%0d ack=%0d, want 0 0", bus.mem_we, bus.game_ack);
      end
    end
    cyc(); bus.game_req = 1'b0;
  endtask

  task automatic test_write_window();
    start_frame();
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 6'd10; bus.game_wdata = 2'd2;
    settle();
    n_vec++;
    if (frame_start !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL write_T: got fs=%0d we=%0d, want 1 0", frame_start, bus.mem_we);
    end
    cyc(); settle();
    n_vec++;
    if (frame_start !== 1'b0 || bus.mem_we !== 1'b0 || bus.game_ack !== 1'b0) begin
      n_err++;
      $display("FAIL write_T1: got fs=%0d we=%0d ack=%0d, want 0 0 0", frame_start, bus.mem_we, bus.game_ack);
    end
    cyc(); settle();
    n_vec++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd10 || bus.mem_wdata !== 2'd2) begin
      n_err++;
      $display("FAIL write_T2: got we=%0d addr=%0d wd=%0d, want 1 10 2", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    cyc(); settle();
    n_vec++;
    if (bus.game_ack !== 1'b1) begin
      n_err++;
      $display("FAIL write_T3_ack: got %0d want 1", bus.game_ack);
    end
    cyc(); bus.game_req = 1'b0;
    ref_mem[10] = 2'd2;
    repeat (4) cyc();
  endtask

  task automatic test_board_edges();
    int ex [6] = '{95, 96, 543, 544, 288, 224};
    int ey [6] = '{48, 48, 431, 431, 112, 112};
    bit e_in [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int e_ad [6] = '{0, 0, 41, 0, 10, 9};
    for (int i = 0; i < 6; i++) begin
      cyc(); x_pixel = 11'(ex[i]); y_pixel = 11'(ey[i]); vid_enable = 1'b1;
      cyc(); settle();
      n_vec++;
      if (bus.mem_addr !== AW'(e_ad[i])) begin
        n_err++;
        $display("FAIL edge_addr(%0d,%0d): got %0d want %0d", ex[i], ey[i], bus.mem_addr, e_ad[i]);
      end
      cyc(); settle();
      n_vec++;
      if (pix_in_board !== e_in[i] || pix_cell !== (e_in[i] ? ref_mem[e_ad[i]] : 2'b00)) begin
        n_err++;
        $display("FAIL edge_pix(%0d,%0d): got in=%0d cell=%0d want in=%0d cell=%0d", ex[i], ey[i],
                 pix_in_board, pix_cell, e_in[i], e_in[i] ? ref_mem[e_ad[i]] : 2'b00);
      end
    end
    cyc(); vid_enable = 1'b0;
  endtask

  task automatic test_pending_read();
    int lat;
    cyc(); vid_enable = 1'b1;
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 6'd10;
    for (int i = 0; i < 6; i++) begin
      cyc(); settle();
      n_vec++;
      if (bus.game_ack !== 1'b0) begin
        n_err++;
        $display("FAIL pending_no_ack: got %0d want 0", bus.game_ack);
      end
    end
    start_frame(); vid_enable = 1'b0; settle();
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc(); settle();
      if (bus.game_ack === 1'b1) begin lat = c; break; end
    end
    n_vec++;
    if (lat != 3 || bus.game_rdata !== ref_mem[10]) begin
      n_err++;
      $display("FAIL pending_read: got lat=%0d rd=%0d want lat=3 rd=%0d", lat, bus.game_rdata, ref_mem[10]);
    end
    cyc(); bus.game_req = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_window_close();
    int lat;
    // Request arriving with the counter at 1 must not be granted.
    start_frame(); bus.game_req = 1'b0; settle();
    repeat (5) cyc();
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 6'd10;
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      n_vec++;
      if (bus.game_ack !== 1'b0) begin
        n_err++;
        $display("FAIL close_cnt1_ack: got %0d want 0", bus.game_ack);
      end
    end
    start_frame(); settle();
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc(); settle();
      if (bus.game_ack === 1'b1) begin lat = c; break; end
    end
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL close_next_frame_lat: got %0d want 3", lat);
    end
    cyc(); bus.game_req = 1'b0;
    repeat (4) cyc();
    // Counter at 2 is still inside the window.
    start_frame(); settle();
    repeat (4) cyc();
    bus.game_req = 1'b1;
    cyc(); cyc(); settle();
    n_vec++;
    if (bus.game_ack !== 1'b1 || bus.game_rdata !== ref_mem[10]) begin
      n_err++;
      $display("FAIL close_cnt2_ack: got ack=%0d rd=%0d want 1 %0d", bus.game_ack, bus.game_rdata, ref_mem[10]);
    end
    cyc(); bus.game_req = 1'b0;
    repeat (4) cyc();
    // Active video mid-window closes it immediately.
    start_frame(); settle();
    cyc(); vid_enable = 1'b1; bus.game_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); settle();
      n_vec++;
      if (bus.game_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
        n_err++;
        $display("FAIL close_vid_enable: got ack=%0d we=%0d want 0 0", bus.game_ack, bus.mem_we);
      end
    end
    start_frame(); vid_enable = 1'b0; settle();
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc(); settle();
      if (bus.game_ack === 1'b1) begin lat = c; break; end
    end
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL close_vid_next_lat: got %0d want 3", lat);
    end
    cyc(); bus.game_req = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_back_to_back();
    start_frame();
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 6'd3; bus.game_wdata = 2'd1;
    settle();
    repeat (3) cyc();
    n_vec++;
    if (bus.game_ack !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first_ack: got %0d want 1", bus.game_ack);
    end
    ref_mem[3] = 2'd1;
    cyc(); bus.game_addr = 6'd4; bus.game_wdata = 2'd2;
    cyc(); settle();
    n_vec++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd4) begin
      n_err++;
      $display("FAIL b2b_second_access: got we=%0d addr=%0d want 1 4", bus.mem_we, bus.mem_addr);
    end
    cyc(); settle();
    n_vec++;
    if (bus.game_ack !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second_ack: got %0d want 1", bus.game_ack);
    end
    ref_mem[4] = 2'd2;
    cyc(); bus.game_req = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_out_of_range();
    start_frame();
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 6'd45; bus.game_wdata = 2'd3;
    settle();
    cyc(); cyc(); settle();
    n_vec++;
    if (bus.mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL oor_we: got %0d want 0", bus.mem_we);
    end
    cyc(); settle();
    n_vec++;
    if (bus.game_ack !== 1'b1 || bus.game_rdata !== 2'b00) begin
      n_err++;
      $display("FAIL oor_ack: got ack=%0d rd=%0d want 1 0", bus.game_ack, bus.game_rdata);
    end
    cyc(); bus.game_req = 1'b0;
    n_vec++;
    if (ram[45] !== 2'b00) begin
      n_err++;
      $display("FAIL oor_ram: got %0d want 0", ram[45]);
    end
    repeat (4) cyc();
  endtask

  task automatic test_reset_mid();
    int lat;
    start_frame();
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 6'd20; bus.game_wdata = 2'd3;
    settle();
    cyc(); cyc(); clr = 1'b0; settle();
    n_vec++;
    if (bus.mem_we !== 1'b0 || bus.game_ack !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abandon: got we=%0d ack=%0d want 0 0", bus.mem_we, bus.game_ack);
    end
    cyc(); clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      n_vec++;
      if (bus.game_ack !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_no_ack: got %0d want 0", bus.game_ack);
      end
    end
    n_vec++;
    if (ram[20] !== ref_mem[20]) begin
      n_err++;
      $display("FAIL rstmid_ram: got %0d want %0d", ram[20], ref_mem[20]);
    end
    start_frame(); settle();
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      cyc(); settle();
      if (bus.game_ack === 1'b1) begin lat = c; break; end
    end
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL rstmid_retry_lat: got %0d want 3", lat);
    end
    ref_mem[20] = 2'd3;
    cyc(); bus.game_req = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_random_access();
    int lat;
    bit early;
    for (int it = 0; it < 24; it++) begin
      bus.game_we    = 1'($urandom_range(0, 1));
      bus.game_addr  = 6'($urandom_range(0, 47));
      bus.game_wdata = 2'($urandom_range(0, 3));
      early = 1'($urandom_range(0, 1));
      cyc(); vid_enable = 1'($urandom_range(0, 1));
      if (early) bus.game_req = 1'b1;
      repeat (2) cyc();
      start_frame(); vid_enable = 1'b0; bus.game_req = 1'b1; settle();
      lat = -1;
      for (int c = 1; c <= 10; c++) begin
        cyc(); settle();
        if (bus.game_ack === 1'b1) begin lat = c; break; end
      end
      n_vec++;
      if (lat != 3) begin
        n_err++;
        $display("FAIL rand_ack_lat[%0d]: got %0d want 3", it, lat);
      end
      if (!bus.game_we) begin
        n_vec++;
        if (bus.game_rdata !== ref_mem[bus.game_addr]) begin
          n_err++;
          $display("FAIL rand_rdata[%0d] addr=%0d: got %0d want %0d", it, bus.game_addr,
                   bus.game_rdata, ref_mem[bus.game_addr]);
        end
      end else if (bus.game_addr < 6'(NCELLS)) begin
        ref_mem[bus.game_addr] = bus.game_wdata;
      end
      cyc(); bus.game_req = 1'b0;
      repeat (4) cyc();
    end
    for (int a = 0; a < 64; a++) begin
      n_vec++;
      if (ram[a] !== ref_mem[a]) begin
        n_err++;
        $display("FAIL rand_ram[%0d]: got %0d want %0d", a, ram[a], ref_mem[a]);
      end
    end
  endtask

  task automatic test_random_pixels();
    bit         q_in [$];
    logic [1:0] q_cell [$];
    bit         inb, vid, e_in;
    logic [1:0] e_cell;
    int         x, y, addr;
    for (int k = 0; k < 300; k++) begin
      x = ($urandom_range(0, 1) == 1) ? int'($urandom_range(64, 600)) : int'($urandom_range(0, 799));
      y = ($urandom_range(0, 1) == 1) ? int'($urandom_range(32, 470)) : int'($urandom_range(0, 524));
      vid = ($urandom_range(0, 3) != 0);
      ref_pix(x, y, inb, addr);
      cyc(); x_pixel = 11'(x); y_pixel = 11'(y); vid_enable = vid;
      q_in.push_back(inb && vid);
      q_cell.push_back((inb && vid) ? ref_mem[addr] : 2'b00);
      settle();
      if (q_in.size() == 3) begin
        e_in   = q_in.pop_front();
        e_cell = q_cell.pop_front();
        n_vec++;
        if (pix_in_board !== e_in || pix_cell !== e_cell) begin
          n_err++;
          $display("FAIL rand_pix[%0d]: got in=%0d cell=%0d want in=%0d cell=%0d", k,
                   pix_in_board, pix_cell, e_in, e_cell);
        end
      end
    end
    cyc(); vid_enable = 1'b0;
  endtask

  initial begin
    bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_addr = '0; bus.game_wdata = '0;
    test_reset();
    test_write_window();
    test_board_edges();
    test_pending_read();
    test_window_close();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random_access();
    test_random_pixels();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
